// File: rtl/ti_pkg.sv
// Shared definitions for the threshold-implementation share generator:
// FSM states, LFSR constants and the LFSR next-state function.
package ti_pkg;

  typedef enum logic [1:0] {
    SEED_WAIT = 2'd0,
    RUN       = 2'd1,
    RESEED    = 2'd2
  } ti_state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  // Galois step: shift right, fold the taps back in when a 1 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ti_lfsr16.sv
// 16-bit Galois LFSR mask source; load wins over step, and a zero seed
// is replaced by the default so the register never locks up.
module ti_lfsr16
  import ti_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_r;
  logic [15:0] seed_fix_s;

  // Substitute the default for an all-zero seed.
  always_comb begin
    seed_fix_s = seed;
    if (seed == 16'h0000) begin
      seed_fix_s = LFSR_DEFAULT;
    end else begin
      seed_fix_s = seed;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LFSR_DEFAULT;
    end else if (load) begin
      state_r <= seed_fix_s;
    end else if (step) begin
      state_r <= lfsr_next(state_r);
    end
  end

  assign state = state_r;

endmodule

// File: rtl/ti_share_gen.sv
// ti_share_gen: masks an S-box input into {data^mask, mask} shares.
// Define TI_SHARE_GLITCH_REG_EN for a second output register stage (latency 2).
module ti_share_gen
  import ti_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SHARE_W = 2 * DATA_W
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [15:0]        seed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHARE_W-1:0] out_shares,
  output logic [15:0]        busy_cnt
);

  ti_state_e          state_r;
  ti_state_e          state_nxt_s;
  logic               in_ready_s;
  logic               room_s;
  logic               accept_s;
  logic [15:0]        lfsr_s;
  logic [DATA_W-1:0]  mask_s;
  logic [SHARE_W-1:0] shares_nxt_s;
  logic               out_valid_r;
  logic [SHARE_W-1:0] out_shares_r;
  logic [15:0]        busy_cnt_r;

  assign mask_s       = lfsr_s[DATA_W-1:0];
  assign shares_nxt_s = SHARE_W'({in_data ^ mask_s, mask_s});
  assign accept_s     = in_valid && in_ready_s;

  // Seed loads take priority, so an accept coinciding with a load uses the old mask.
  ti_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load),
    .seed  (seed),
    .step  (accept_s),
    .state (lfsr_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SEED_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and in_ready decode; inputs are only taken in RUN.
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    case (state_r)
      SEED_WAIT: begin
        in_ready_s = 1'b0;
        if (seed_load) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = SEED_WAIT;
        end
      end
      RUN: begin
        in_ready_s = room_s;
        if (seed_load) begin
          state_nxt_s = RESEED;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RESEED: begin
        in_ready_s  = 1'b0;
        state_nxt_s = RUN;
      end
      default: begin
        in_ready_s  = 1'b0;
        state_nxt_s = SEED_WAIT;
      end
    endcase
  end

`ifdef TI_SHARE_GLITCH_REG_EN
  logic               s1_valid_r;
  logic [SHARE_W-1:0] s1_shares_r;
  logic               s1_move_s;

  assign s1_move_s = s1_valid_r && (!out_valid_r || out_ready);
  assign room_s    = !(s1_valid_r && out_valid_r) || out_ready;

  // First stage: captures the freshly masked word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_shares_r <= {SHARE_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r  <= 1'b1;
      s1_shares_r <= shares_nxt_s;
    end else if (s1_move_s) begin
      s1_valid_r  <= 1'b0;
    end
  end

  // Second stage: output register fed only from the first stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_shares_r <= {SHARE_W{1'b0}};
    end else if (s1_move_s) begin
      out_valid_r  <= 1'b1;
      out_shares_r <= s1_shares_r;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end
`else
  assign room_s = !out_valid_r || out_ready;

  // Single output register; an accept during a pop overwrites with valid held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_shares_r <= {SHARE_W{1'b0}};
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      out_shares_r <= shares_nxt_s;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end
`endif

  // Accept counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_r <= 16'h0000;
    end else if (accept_s) begin
      busy_cnt_r <= busy_cnt_r + 16'h0001;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_shares = out_shares_r;
  assign busy_cnt   = busy_cnt_r;

endmodule
